// File: rtl/c_cond_merge_pkg.sv
// Shared types and helpers for the conditional merge (c_cond_merge).
// Contents: FSM state enum, select-width derivation, default watchdog limit.
package cmerge_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam int unsigned TIMEOUT_DEFAULT = 255;

    // Width of an index that can address n sources (at least one bit).
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 32'd1 : 32'($clog2(n));
    endfunction

endpackage

// File: rtl/c_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req : request vector, one bit per source
//   ptr : index of the most recently served source
//   any : at least one request is set
//   idx : first set request scanning ptr+1, ptr+2, ... modulo NUM_IN
module c_rr_pick
    import cmerge_pkg::*;
#(
    parameter  int unsigned NUM_IN = 5,
    localparam int unsigned SELW   = sel_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0] req,
    input  logic [SELW-1:0]   ptr,
    output logic              any,
    output logic [SELW-1:0]   idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Walk the ring from farthest to nearest so the entry just after ptr wins.
        for (int unsigned k = NUM_IN; k >= 1; k--) begin
            if (req[SELW'((32'(ptr) + k) % NUM_IN)]) begin
                idx = SELW'((32'(ptr) + k) % NUM_IN);
            end
        end
    end

endmodule

// File: rtl/c_cond_merge.sv
// Clocked N-to-1 round-robin merge for the drive/free micropipeline protocol.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_drive       : per-source drive events
//   o_free        : one-cycle free pulse back to the granted source
//   o_driveNext   : one-cycle drive pulse downstream
//   i_freeNext    : downstream free events
//   o_sel         : granted source index (for the downstream data mux)
//   o_busy        : high while a transaction is outstanding (WAIT)
//   o_err         : sticky protocol-error flag
//   o_timeout     : sticky watchdog flag
// Optional macro CMERGE_TIMEOUT_EN enables a WAIT watchdog of TIMEOUT cycles;
// without it o_timeout is tied low and WAIT lasts until i_freeNext.
module c_cond_merge
    import cmerge_pkg::*;
#(
    parameter  int unsigned NUM_IN  = 5,
    parameter  int unsigned TIMEOUT = TIMEOUT_DEFAULT,
    localparam int unsigned SELW    = sel_width(NUM_IN)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [NUM_IN-1:0] i_drive,
    output logic [NUM_IN-1:0] o_free,
    output logic              o_driveNext,
    input  logic              i_freeNext,
    output logic [SELW-1:0]   o_sel,
    output logic              o_busy,
    output logic              o_err,
    output logic              o_timeout
);

    // Elaboration-time parameter range guards.
    if (NUM_IN < 2 || NUM_IN > 16) begin : g_bad_num_in
        $error("c_cond_merge: NUM_IN must be in 2..16");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("c_cond_merge: TIMEOUT must be in 1..65535");
    end

    state_t            state_q, state_d;
    logic [NUM_IN-1:0] pending_q, pending_d;
    logic [SELW-1:0]   ptr_q, ptr_d;
    logic [SELW-1:0]   sel_q, sel_d;
    logic              drive_q, drive_d;
    logic [NUM_IN-1:0] free_q, free_d;
    logic              err_q, err_d;
    logic              pick_any;
    logic [SELW-1:0]   pick_idx;

`ifdef CMERGE_TIMEOUT_EN
    localparam int unsigned TW = (TIMEOUT < 256) ? 8 : 16;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          tout_q, tout_d;
`endif

    c_rr_pick #(
        .NUM_IN (NUM_IN)
    ) u_pick (
        .req (pending_q),
        .ptr (ptr_q),
        .any (pick_any),
        .idx (pick_idx)
    );

    // Next-state and output decode.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q | i_drive;
        ptr_d     = ptr_q;
        sel_d     = sel_q;
        drive_d   = 1'b0;
        free_d    = '0;
        // A drive onto an already pending source is dropped and flagged.
        err_d     = err_q | (|(i_drive & pending_q));
`ifdef CMERGE_TIMEOUT_EN
        tmr_d     = tmr_q;
        tout_d    = tout_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_freeNext) begin
                    err_d = 1'b1;
                end
                // Hold off the grant while the previous free is on the wire,
                // keeping drive pulses at least three cycles apart.
                if (pick_any && !(|free_q)) begin
                    sel_d   = pick_idx;
                    drive_d = 1'b1;
                    state_d = WAIT;
`ifdef CMERGE_TIMEOUT_EN
                    tmr_d   = '0;
`endif
                end
            end
            WAIT: begin
                if (i_freeNext) begin
                    free_d[sel_q]    = 1'b1;
                    pending_d[sel_q] = 1'b0;
                    ptr_d            = sel_q;
                    state_d          = IDLE;
                end
`ifdef CMERGE_TIMEOUT_EN
                else if (tmr_q == TW'(TIMEOUT - 1)) begin
                    // Abandon the stalled grant without freeing the source.
                    tout_d           = 1'b1;
                    pending_d[sel_q] = 1'b0;
                    ptr_d            = sel_q;
                    state_d          = IDLE;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            ptr_q     <= SELW'(NUM_IN - 1);
            sel_q     <= '0;
            drive_q   <= 1'b0;
            free_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            drive_q   <= drive_d;
            free_q    <= free_d;
            err_q     <= err_d;
        end
    end

`ifdef CMERGE_TIMEOUT_EN
    // Watchdog registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmr_q  <= '0;
            tout_q <= 1'b0;
        end else begin
            tmr_q  <= tmr_d;
            tout_q <= tout_d;
        end
    end
    assign o_timeout = tout_q;
`else
    assign o_timeout = 1'b0;
`endif

    assign o_free      = free_q;
    assign o_driveNext = drive_q;
    assign o_sel       = sel_q;
    assign o_busy      = (state_q == WAIT);
    assign o_err       = err_q;

endmodule
